// File: rtl/uart_tx_arb_pkg.sv
// ---------------------------------------------------------------------------
// uart_tx_arb_pkg
// Shared definitions for the UART transmit arbiter:
//   arb_state_e   - arbiter FSM state (IDLE / LOCKED)
//   UART_NEWLINE  - byte value that terminates a message and ends a grant
// ---------------------------------------------------------------------------
package uart_tx_arb_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam logic [7:0] UART_NEWLINE = 8'h0A;

endpackage

// File: rtl/uart_tx_rr_pick.sv
// ---------------------------------------------------------------------------
// uart_tx_rr_pick
// Purely combinational round-robin picker. Searches req starting at ptr and
// wrapping modulo N_REQ; the first asserted request found wins.
// Ports:
//   req  [N_REQ-1:0] - request vector
//   ptr  [IDXW-1:0]  - highest-priority index (must be < N_REQ)
//   any              - at least one request asserted
//   idx  [IDXW-1:0]  - winning index (0 when any is low)
// ---------------------------------------------------------------------------
module uart_tx_rr_pick
    import uart_tx_arb_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int IDXW  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDXW-1:0]  ptr,
    output logic             any,
    output logic [IDXW-1:0]  idx
);

    logic [IDXW:0] sum_s;
    logic [IDXW:0] cand_s;
    logic          hit_s;

    // Walk offsets from farthest to nearest so the nearest hit to ptr is the last write.
    always_comb begin
        any    = 1'b0;
        idx    = '0;
        sum_s  = '0;
        cand_s = '0;
        hit_s  = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            sum_s  = {1'b0, ptr} + (IDXW + 1)'(k);
            cand_s = (sum_s >= (IDXW + 1)'(N_REQ)) ? (sum_s - (IDXW + 1)'(N_REQ)) : sum_s;
            hit_s  = req[cand_s[IDXW-1:0]];
            any    = any | hit_s;
            idx    = hit_s ? cand_s[IDXW-1:0] : idx;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Grants one of N_REQ byte-stream requesters exclusive access to a single
// UART transmitter. A grant lasts until a newline is sent, MAX_BURST bytes
// have been sent, or the owner stays idle for IDLE_TIMEOUT cycles. Winners
// are chosen round-robin; the data path from owner to transmitter is purely
// combinational.
// Ports:
//   clock, reset            - clock and synchronous active-high reset
//   in_valid/in_bits        - per-requester byte stream (byte i at [8i+7:8i])
//   in_ready                - per-requester accept (only the owner's can be high)
//   out_valid/out_bits      - byte toward the transmitter
//   out_ready               - transmitter accept
//   busy                    - a requester currently holds the grant
//   grant_idx               - current or most recent owner
// ---------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter  int N_REQ        = 4,
    parameter  int MAX_BURST    = 64,
    parameter  int IDLE_TIMEOUT = 256,
    localparam int IDXW         = $clog2(N_REQ)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     in_valid,
    input  logic [8*N_REQ-1:0]   in_bits,
    output logic [N_REQ-1:0]     in_ready,
    output logic                 out_valid,
    output logic [7:0]           out_bits,
    input  logic                 out_ready,
    output logic                 busy,
    output logic [IDXW-1:0]      grant_idx
);

    localparam int              BCW        = $clog2(MAX_BURST + 1);
    localparam int              ICW        = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [BCW-1:0]  BURST_LAST = BCW'(MAX_BURST - 1);
    localparam logic [ICW-1:0]  IDLE_LAST  = ICW'(IDLE_TIMEOUT - 1);
    localparam logic [IDXW-1:0] IDX_MAX    = IDXW'(N_REQ - 1);

    arb_state_e       state_r, state_next_s;
    logic [IDXW-1:0]  owner_r, owner_next_s;
    logic [IDXW-1:0]  rr_ptr_r, rr_ptr_next_s;
    logic [BCW-1:0]   burst_cnt_r, burst_cnt_next_s;
    logic [ICW-1:0]   idle_cnt_r, idle_cnt_next_s;

    logic             pick_any_s;
    logic [IDXW-1:0]  pick_idx_s;
    logic             locked_s;
    logic             owner_valid_s;
    logic [7:0]       owner_bits_s;
    logic             xfer_s;
    logic             last_byte_s;
    logic             timeout_s;
    logic             release_s;

    uart_tx_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req (in_valid),
        .ptr (rr_ptr_r),
        .any (pick_any_s),
        .idx (pick_idx_s)
    );

    // locked_s is forced low during reset so nothing is forwarded or accepted in a reset cycle.
    assign locked_s      = (state_r == LOCKED) && !reset;
    assign owner_valid_s = in_valid[owner_r];
    assign owner_bits_s  = in_bits[{owner_r, 3'b000} +: 8];
    assign xfer_s        = locked_s && owner_valid_s && out_ready;
    // The burst limit fires on the transfer that would bring the count to MAX_BURST.
    assign last_byte_s   = (owner_bits_s == UART_NEWLINE) || (burst_cnt_r == BURST_LAST);
    // The cycle that would bring idle_cnt to IDLE_TIMEOUT releases instead of counting.
    assign timeout_s     = locked_s && !owner_valid_s && (idle_cnt_r == IDLE_LAST);
    assign release_s     = (xfer_s && last_byte_s) || timeout_s;

    assign busy          = locked_s;
    assign grant_idx     = reset ? '0 : owner_r;

    // State and counter registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= IDLE;
            owner_r     <= '0;
            rr_ptr_r    <= '0;
            burst_cnt_r <= '0;
            idle_cnt_r  <= '0;
        end else begin
            state_r     <= state_next_s;
            owner_r     <= owner_next_s;
            rr_ptr_r    <= rr_ptr_next_s;
            burst_cnt_r <= burst_cnt_next_s;
            idle_cnt_r  <= idle_cnt_next_s;
        end
    end

    // Next-state logic: arbitrate in IDLE, count and release in LOCKED.
    always_comb begin
        state_next_s     = state_r;
        owner_next_s     = owner_r;
        rr_ptr_next_s    = rr_ptr_r;
        burst_cnt_next_s = burst_cnt_r;
        idle_cnt_next_s  = idle_cnt_r;
        case (state_r)
            IDLE: begin
                if (pick_any_s) begin
                    state_next_s = LOCKED;
                    owner_next_s = pick_idx_s;
                end else begin
                    state_next_s = IDLE;
                end
            end
            LOCKED: begin
                if (release_s) begin
                    // Pending requests are re-arbitrated next cycle, leaving one bubble.
                    state_next_s     = IDLE;
                    rr_ptr_next_s    = (owner_r == IDX_MAX) ? '0 : owner_r + IDXW'(1);
                    burst_cnt_next_s = '0;
                    idle_cnt_next_s  = '0;
                end else begin
                    burst_cnt_next_s = xfer_s ? burst_cnt_r + BCW'(1) : burst_cnt_r;
                    idle_cnt_next_s  = owner_valid_s ? '0 : idle_cnt_r + ICW'(1);
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Combinational data path: connect the owner straight to the transmitter.
    always_comb begin
        out_valid = 1'b0;
        out_bits  = 8'h00;
        in_ready  = '0;
        if (locked_s) begin
            out_valid         = owner_valid_s;
            out_bits          = owner_bits_s;
            in_ready[owner_r] = out_ready;
        end else begin
            out_valid = 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Directed bench for uart_tx_arbiter (default parameters). Per-requester
// byte queues drive the inputs; every byte expected at the transmitter is
// pushed to a scoreboard queue by hand, and a monitor compares each
// transfer (byte, owner, in_ready) against it.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int N_REQ = 4;

    logic                 clock = 1'b0;
    logic                 reset;
    logic [N_REQ-1:0]     in_valid;
    logic [8*N_REQ-1:0]   in_bits;
    logic [N_REQ-1:0]     in_ready;
    logic                 out_valid;
    logic [7:0]           out_bits;
    logic                 out_ready;
    logic                 busy;
    logic [1:0]           grant_idx;

    typedef struct packed {
        logic [1:0] idx;
        logic [7:0] data;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       mon_e;
    logic [7:0] tx_q[N_REQ][$];
    int         vectors     = 0;
    int         miscompares = 0;

    uart_tx_arbiter dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_bits   (in_bits),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_bits  (out_bits),
        .out_ready (out_ready),
        .busy      (busy),
        .grant_idx (grant_idx)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every transfer must match the head of the scoreboard.
    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_byte: got 0x%0h from %0d, expected nothing", out_bits, grant_idx);
            end else begin
                mon_e = sb_q.pop_front();
                check("out_bits", {24'd0, out_bits}, {24'd0, mon_e.data});
                check("grant_idx", {30'd0, grant_idx}, {30'd0, mon_e.idx});
                check("in_ready_owner", {28'd0, in_ready}, {28'd0, 4'b0001 << mon_e.idx});
            end
        end
    end

    task automatic drive();
        for (int i = 0; i < N_REQ; i++) begin
            in_valid[i]      = (tx_q[i].size() > 0);
            in_bits[8*i +: 8] = (tx_q[i].size() > 0) ? tx_q[i][0] : 8'h00;
        end
    endtask

    // One clock: capture handshakes before the edge, pop after it, re-drive and settle.
    task automatic step();
        logic [N_REQ-1:0] hs;
        @(negedge clock);
        hs = in_valid & in_ready & {N_REQ{~reset}};
        @(posedge clock);
        #1;
        for (int i = 0; i < N_REQ; i++) begin
            if (hs[i]) void'(tx_q[i].pop_front());
        end
        drive();
        #1;
    endtask

    task automatic load(input int i, input string s);
        for (int k = 0; k < s.len(); k++) tx_q[i].push_back(s[k]);
    endtask

    task automatic expect_byte(input int i, input logic [7:0] b);
        exp_t e;
        e.idx  = 2'(i);
        e.data = b;
        sb_q.push_back(e);
    endtask

    task automatic expect_msg(input int i, input string s);
        for (int k = 0; k < s.len(); k++) expect_byte(i, s[k]);
    endtask

    function automatic int pending();
        int n = sb_q.size();
        for (int i = 0; i < N_REQ; i++) n += tx_q[i].size();
        return n;
    endfunction

    task automatic drain(input string name, input int bound);
        int c = 0;
        while (pending() > 0 && c < bound) begin
            step();
            c++;
        end
        check(name, {31'd0, c < bound}, 32'd1);
        step();
        step();
    endtask

    initial begin
        int   cyc;
        int   idle_seen;
        int   n;
        logic busy_exp [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

        reset     = 1'b1;
        out_ready = 1'b1;
        in_valid  = '0;
        in_bits   = '0;
        @(posedge clock);
        #2;
        step();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {28'd0, in_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_grant_idx", {30'd0, grant_idx}, 32'd0);
        reset = 1'b0;
        step();

        // Requesters 0 and 2 each send "AB\n": 0 first, bubble, then 2.
        load(0, "AB\n");
        load(2, "AB\n");
        expect_msg(0, "AB\n");
        expect_msg(2, "AB\n");
        drive();
        #1;
        for (int k = 0; k < 9; k++) begin
            check($sformatf("t1_busy_c%0d", k), {31'd0, busy}, {31'd0, busy_exp[k]});
            step();
        end
        drain("t1_drain", 20);

        // Requester 1 streams 70 bytes: split after 64 with one idle cycle between grants.
        for (int k = 0; k < 70; k++) begin
            tx_q[1].push_back(8'(8'h20 + k));
            expect_byte(1, 8'(8'h20 + k));
        end
        drive();
        #1;
        cyc       = 0;
        idle_seen = 0;
        while (tx_q[1].size() > 0 && cyc < 200) begin
            if (!busy) idle_seen++;
            cyc++;
            step();
        end
        check("t2_idle_cycles", idle_seen, 32'd2);
        check("t2_total_cycles", cyc, 32'd72);
        n = 0;
        while (busy && n < 400) begin
            n++;
            step();
        end
        check("t2_tail_timeout", n, 32'd256);

        // Requester 3 sends "x" then goes quiet: released after 256 idle cycles.
        load(3, "x");
        expect_msg(3, "x");
        drive();
        #1;
        cyc = 0;
        while (tx_q[3].size() > 0 && cyc < 20) begin
            cyc++;
            step();
        end
        n = 0;
        while (busy && n < 400) begin
            n++;
            step();
        end
        check("t3_timeout", n, 32'd256);
        load(0, "\n");
        expect_msg(0, "\n");
        drive();
        #1;
        check("t3_arb_cycle_busy", {31'd0, busy}, 32'd0);
        step();
        check("t3_regrant_busy", {31'd0, busy}, 32'd1);
        check("t3_regrant_idx", {30'd0, grant_idx}, 32'd0);
        drain("t3_drain", 20);

        // Stall the transmitter for 10 cycles in the middle of "QRS\n".
        load(2, "QRS\n");
        expect_msg(2, "QRS\n");
        drive();
        #1;
        cyc = 0;
        while (tx_q[2].size() > 2 && cyc < 20) begin
            cyc++;
            step();
        end
        out_ready = 1'b0;
        #1;
        for (int k = 0; k < 10; k++) begin
            check("t4_stall_valid", {31'd0, out_valid}, 32'd1);
            check("t4_stall_bits", {24'd0, out_bits}, 32'h53);
            check("t4_stall_ready", {31'd0, in_ready[2]}, 32'd0);
            step();
        end
        out_ready = 1'b1;
        drain("t4_drain", 20);

        // Reset after 2 bytes of "12345": grant abandoned, requester 0 wins next.
        load(3, "12345");
        expect_msg(3, "12");
        drive();
        #1;
        cyc = 0;
        while (tx_q[3].size() > 3 && cyc < 20) begin
            cyc++;
            step();
        end
        reset = 1'b1;
        load(0, "Z\n");
        drive();
        #1;
        check("t5_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("t5_rst_in_ready", {28'd0, in_ready}, 32'd0);
        check("t5_rst_busy", {31'd0, busy}, 32'd0);
        check("t5_rst_grant_idx", {30'd0, grant_idx}, 32'd0);
        step();
        reset = 1'b0;
        tx_q[3].delete();
        load(3, "k\n");
        drive();
        #1;
        check("t5_post_out_valid", {31'd0, out_valid}, 32'd0);
        check("t5_post_busy", {31'd0, busy}, 32'd0);
        expect_msg(0, "Z\n");
        expect_msg(3, "k\n");
        drain("t5_drain", 30);

        // All requesters continuously valid with newline-only messages: strict rotation.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N_REQ; i++) begin
                load(i, "\n");
                expect_msg(i, "\n");
            end
        end
        drive();
        #1;
        drain("t6_drain", 40);

        check("sb_empty", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
